residual_sad_engine: RTL and testbench
======================================

Name: residual_sad_engine

Overview:
Parametrised successor to the per-row residual compute stage in the mosaic-stitching datapath. Subtracts one POI pixel from LANES window pixels of a search-window row each beat and emits registered residuals. Residuals are selectable as wrap, absolute or saturating. Per lane, it also accumulates absolute differences over a POI into sums of absolute differences (SAD) for the match-scoring stage. It adds a valid/ready handshake with backpressure in place of a bare enable.

Parameters:
LANES, 32, parallel lanes (window columns per row)
PIX_W, 8, pixel width in bits
POI_DEPTH, 4, POI row address bits
POI_WIDTH, 4, POI column address bits
ROW_W, 5, window row index width
ACC_W, PIX_W+POI_DEPTH+POI_WIDTH, SAD accumulator width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept beat
in_last  in  1  final POI pixel of current SAD window
mode  in  2  residual mode: 0 wrap, 1 absolute, 2 saturating, 3 reserved (treated as 0)
acc_clr  in  1  synchronous abort; clears SAD accumulators
poi_data  in  PIX_W  POI pixel
w_row_data  in  LANES x PIX_W  window row pixels
w_row  in  ROW_W  window row index
poi_addr  in  POI_DEPTH+POI_WIDTH  POI pixel address
res_valid  out  1  residual output valid
res_ready  in  1  downstream accepts residuals
residuals  out  LANES x PIX_W  per-lane residuals
w_row_wr  out  ROW_W  row index aligned to residuals
poi_addr_wr  out  POI_DEPTH+POI_WIDTH  POI address aligned to residuals
sad_valid  out  1  one-cycle pulse: sad/sad_row valid
sad  out  LANES x ACC_W  per-lane SAD
sad_row  out  ROW_W  w_row of the in_last beat

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on reset. All outputs and accumulators clear to 0 on reset: res_valid, residuals, w_row_wr, poi_addr_wr, sad_valid, sad, sad_row and acc[]. Reset mid-window discards partial sums.
- in_ready = !res_valid || res_ready, combinational. A beat is accepted when in_valid && in_ready.
- Per-lane arithmetic, with A=poi_data and B=w_row_data[i]:
  - Mode 0: (A-B) mod 2^PIX_W.
  - Mode 1: |A-B|.
  - Mode 2: A>B ? A-B : 0.
  - Mode 3: same as mode 0.
  - mode is sampled per accepted beat.
- Residual stage (1-cycle latency):
  - On an accepted beat, residuals, w_row_wr and poi_addr_wr load on the next edge, and res_valid <= 1.
  - If there is no accepted beat and res_ready=1, res_valid <= 0.
  - While res_valid && !res_ready, the outputs hold stable and in_ready=0.
- SAD stage:
  - On an accepted beat, acc[i] += |A-B| regardless of mode. The add saturates at 2^ACC_W-1, with no wrap.
  - On an accepted beat with in_last=1: sad[i] <= acc[i]+|A-B| (saturated), sad_row <= w_row, sad_valid <= 1 for exactly one cycle, and acc[i] <= 0.
  - sad and sad_row hold until the next in_last beat or reset. sad has no backpressure.
- acc_clr:
  - With no accepted beat, acc_clr sets acc[] <= 0 and does not touch sad.
  - When acc_clr and an accepted beat occur in the same cycle, the clear applies first: acc[i] <= |A-B|. If in_last is also set, sad[i] <= |A-B|.
- A SAD window of a single beat (in_last on the first beat) produces sad = that beat's absolute differences.
- Non-accepted cycles change no state except the res_valid drain.

Test Plan:
1. Reset mid-stream: accept 3 beats, assert reset asynchronously between edges -> all outputs and acc read 0 immediately. The next window of 2 beats gives a SAD that excludes pre-reset data.
2. Mode sweep, LANES=32, poi_data=10, w_row_data[i]=i: cycle after accept shows
   - mode 0: residuals[15]=251, residuals[3]=7;
   - mode 1: residuals[15]=5, residuals[3]=7;
   - mode 2: residuals[15]=0, residuals[3]=7;
   - mode 3: same as mode 0.
3. SAD window: 4 beats of poi_data=200, w_row_data all 50, w_row=7, in_last on 4th -> one-cycle sad_valid, every sad[i]=600, sad_row=7. The next window starts from 0.
4. Backpressure: hold res_ready=0 with 2 beats offered -> the first is captured, in_ready=0, residuals stable over 5 cycles, the second is not accepted. Raising res_ready delivers beat 1 then beat 2 in order with no loss or duplication.
5. Saturation: force 256 beats of |A-B|=255 with ACC_W=12 -> sad[i]=4095, not wrapped.
6. acc_clr with simultaneous in_last beat of |A-B|=9 after 3 prior beats -> sad[i]=9, sad_valid=1. acc_clr alone after 2 beats -> sad unchanged.

Source files
------------

// File: rtl/residual_sad_engine.sv
// Per-lane residual and SAD engine: one POI pixel minus LANES window pixels per accepted beat,
// registered residuals behind a valid/ready handshake, and saturating per-lane SAD accumulation.
module residual_sad_engine #(
  parameter int unsigned LANES     = 32,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned POI_DEPTH = 4,
  parameter int unsigned POI_WIDTH = 4,
  parameter int unsigned ROW_W     = 5,
  parameter int unsigned ACC_W     = PIX_W + POI_DEPTH + POI_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_last,
  input  logic [1:0]                           mode,
  input  logic                                 acc_clr,
  input  logic [PIX_W-1:0]                     poi_data,
  input  logic [LANES-1:0][PIX_W-1:0]          w_row_data,
  input  logic [ROW_W-1:0]                     w_row,
  input  logic [POI_DEPTH+POI_WIDTH-1:0]       poi_addr,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [LANES-1:0][PIX_W-1:0]          residuals,
  output logic [ROW_W-1:0]                     w_row_wr,
  output logic [POI_DEPTH+POI_WIDTH-1:0]       poi_addr_wr,
  output logic                                 sad_valid,
  output logic [LANES-1:0][ACC_W-1:0]          sad,
  output logic [ROW_W-1:0]                     sad_row
);

  localparam int unsigned AddrW = POI_DEPTH + POI_WIDTH;

  logic                             accept;
  logic [LANES-1:0][PIX_W-1:0]      wrap_diff, abs_diff;
  logic [LANES-1:0][ACC_W-1:0]      acc_base, acc_sum;
  logic [LANES-1:0][ACC_W:0]        sum_ext;

  logic                             res_valid_d, res_valid_q;
  logic [LANES-1:0][PIX_W-1:0]      res_d, res_q;
  logic [ROW_W-1:0]                 w_row_wr_d, w_row_wr_q;
  logic [AddrW-1:0]                 poi_addr_wr_d, poi_addr_wr_q;
  logic                             sad_valid_d, sad_valid_q;
  logic [LANES-1:0][ACC_W-1:0]      sad_d, sad_q, acc_d, acc_q;
  logic [ROW_W-1:0]                 sad_row_d, sad_row_q;

  assign in_ready = !res_valid_q || res_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    wrap_diff = '0;
    abs_diff  = '0;
    acc_base  = '0;
    sum_ext   = '0;
    acc_sum   = '0;
    res_d     = res_q;
    acc_d     = acc_q;
    sad_d     = sad_q;
    for (int i = 0; i < LANES; i++) begin
      wrap_diff[i] = poi_data - w_row_data[i];
      abs_diff[i]  = (poi_data >= w_row_data[i]) ? wrap_diff[i] : (w_row_data[i] - poi_data);
      // A concurrent clear discards the running sum before this beat is added.
      acc_base[i]  = acc_clr ? '0 : acc_q[i];
      sum_ext[i]   = {1'b0, acc_base[i]} + {{(ACC_W + 1 - PIX_W){1'b0}}, abs_diff[i]};
      acc_sum[i]   = sum_ext[i][ACC_W] ? '1 : sum_ext[i][ACC_W-1:0];
      if (accept) begin
        unique case (mode)
          2'd1:    res_d[i] = abs_diff[i];
          2'd2:    res_d[i] = (poi_data > w_row_data[i]) ? wrap_diff[i] : '0;
          default: res_d[i] = wrap_diff[i];
        endcase
        acc_d[i] = in_last ? '0 : acc_sum[i];
        if (in_last) begin
          sad_d[i] = acc_sum[i];
        end
      end else if (acc_clr) begin
        acc_d[i] = '0;
      end
    end
  end

  always_comb begin
    res_valid_d   = res_valid_q;
    w_row_wr_d    = w_row_wr_q;
    poi_addr_wr_d = poi_addr_wr_q;
    sad_row_d     = sad_row_q;
    sad_valid_d   = accept && in_last;
    if (accept) begin
      res_valid_d   = 1'b1;
      w_row_wr_d    = w_row;
      poi_addr_wr_d = poi_addr;
      if (in_last) begin
        sad_row_d = w_row;
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q   <= 1'b0;
      res_q         <= '0;
      w_row_wr_q    <= '0;
      poi_addr_wr_q <= '0;
      sad_valid_q   <= 1'b0;
      sad_q         <= '0;
      sad_row_q     <= '0;
      acc_q         <= '0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_q         <= res_d;
      w_row_wr_q    <= w_row_wr_d;
      poi_addr_wr_q <= poi_addr_wr_d;
      sad_valid_q   <= sad_valid_d;
      sad_q         <= sad_d;
      sad_row_q     <= sad_row_d;
      acc_q         <= acc_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign residuals   = res_q;
  assign w_row_wr    = w_row_wr_q;
  assign poi_addr_wr = poi_addr_wr_q;
  assign sad_valid   = sad_valid_q;
  assign sad         = sad_q;
  assign sad_row     = sad_row_q;

endmodule

// File: tb/tb_residual_sad_engine.sv
// Bench for residual_sad_engine: integer-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_residual_sad_engine;

  localparam int unsigned LANES = 32;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned POI_DEPTH = 4;
  localparam int unsigned POI_WIDTH = 4;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned ACC_W = 12;
  localparam int unsigned ADDR_W = POI_DEPTH + POI_WIDTH;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int PIX_M = 1 << PIX_W;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, in_last, acc_clr, res_valid, res_ready, sad_valid;
  logic [1:0] mode;
  logic [PIX_W-1:0] poi_data;
  logic [LANES-1:0][PIX_W-1:0] w_row_data, residuals;
  logic [ROW_W-1:0] w_row, w_row_wr, sad_row;
  logic [ADDR_W-1:0] poi_addr, poi_addr_wr;
  logic [LANES-1:0][ACC_W-1:0] sad;

  int checks = 0;
  int errors = 0;

  residual_sad_engine #(
    .LANES(LANES), .PIX_W(PIX_W), .POI_DEPTH(POI_DEPTH), .POI_WIDTH(POI_WIDTH),
    .ROW_W(ROW_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .mode(mode), .acc_clr(acc_clr), .poi_data(poi_data), .w_row_data(w_row_data),
    .w_row(w_row), .poi_addr(poi_addr), .res_valid(res_valid), .res_ready(res_ready),
    .residuals(residuals), .w_row_wr(w_row_wr), .poi_addr_wr(poi_addr_wr),
    .sad_valid(sad_valid), .sad(sad), .sad_row(sad_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on accepted beats.
  int m_res[LANES];
  int m_acc[LANES];
  int m_sad[LANES];
  bit m_rv, m_sv;
  int m_row_wr, m_addr_wr, m_sad_row;
  int ma, mb, md, ms;
  bit m_take;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rv = 0; m_sv = 0; m_row_wr = 0; m_addr_wr = 0; m_sad_row = 0;
      for (int i = 0; i < LANES; i++) begin
        m_res[i] = 0; m_acc[i] = 0; m_sad[i] = 0;
      end
    end else begin
      m_take = in_valid && (!m_rv || res_ready);
      m_sv = 0;
      if (m_take) begin
        for (int i = 0; i < LANES; i++) begin
          ma = int'(poi_data);
          mb = int'(w_row_data[i]);
          md = (ma > mb) ? ma - mb : mb - ma;
          case (mode)
            2'd1: m_res[i] = md;
            2'd2: m_res[i] = (ma > mb) ? ma - mb : 0;
            default: m_res[i] = ((ma - mb) % PIX_M + PIX_M) % PIX_M;
          endcase
          ms = (acc_clr ? 0 : m_acc[i]) + md;
          if (ms > ACC_MAX) ms = ACC_MAX;
          if (in_last) begin
            m_sad[i] = ms;
            m_acc[i] = 0;
          end else begin
            m_acc[i] = ms;
          end
        end
        m_rv = 1;
        m_row_wr = int'(w_row);
        m_addr_wr = int'(poi_addr);
        if (in_last) begin
          m_sv = 1;
          m_sad_row = int'(w_row);
        end
      end else begin
        if (acc_clr) for (int i = 0; i < LANES; i++) m_acc[i] = 0;
        if (res_ready) m_rv = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_rv || res_ready);
    chk("res_valid", res_valid, m_rv);
    chk("sad_valid", sad_valid, m_sv);
    chk("sad_row", sad_row, m_sad_row);
    chk("w_row_wr", w_row_wr, m_row_wr);
    chk("poi_addr_wr", poi_addr_wr, m_addr_wr);
    for (int i = 0; i < LANES; i++) begin
      chk($sformatf("residuals[%0d]", i), residuals[i], m_res[i]);
      chk($sformatf("sad[%0d]", i), sad[i], m_sad[i]);
    end
  end

  // Delivery log for the backpressure scenario.
  bit rec = 0;
  logic [ADDR_W-1:0] deliv[$];
  always @(negedge clk) if (rec && res_valid && res_ready) deliv.push_back(poi_addr_wr);

  // Offer one beat and hold it until accepted; returns 2 time units after the accepting edge.
  task automatic beat(input int poi, input int wbase, input bit ramp, input int row,
                      input int addr, input int md_i, input bit last, input bit clr);
    bit ok;
    poi_data = PIX_W'(poi);
    for (int i = 0; i < LANES; i++) w_row_data[i] = PIX_W'(ramp ? wbase + i : wbase);
    w_row = ROW_W'(row);
    poi_addr = ADDR_W'(addr);
    mode = md_i[1:0];
    in_last = last;
    acc_clr = clr;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
    end
    if (!ok) begin
      errors++;
      $display("FAIL beat_accept: got no acceptance expected acceptance within 50 cycles");
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    acc_clr = 1'b0;
  endtask

  task automatic idle(input bit clr);
    acc_clr = clr;
    @(posedge clk);
    #2;
    acc_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_last = 0; acc_clr = 0; mode = 0; res_ready = 1;
    poi_data = 0; w_row_data = '0; w_row = 0; poi_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset res_valid", res_valid, 0);
    chk("reset sad_valid", sad_valid, 0);
    chk("reset residuals[0]", residuals[0], 0);
    chk("reset sad[0]", sad[0], 0);
    #1;
    reset = 1'b0;

    // Mode sweep: poi 10, window pixel i in lane i.
    beat(10, 0, 1, 1, 8'h01, 0, 0, 0);
    chk("mode0 residuals[15]", residuals[15], 251);
    chk("mode0 residuals[3]", residuals[3], 7);
    beat(10, 0, 1, 1, 8'h02, 1, 0, 0);
    chk("mode1 residuals[15]", residuals[15], 5);
    chk("mode1 residuals[3]", residuals[3], 7);
    beat(10, 0, 1, 1, 8'h03, 2, 0, 0);
    chk("mode2 residuals[15]", residuals[15], 0);
    chk("mode2 residuals[3]", residuals[3], 7);
    beat(10, 0, 1, 1, 8'h04, 3, 0, 0);
    chk("mode3 residuals[15]", residuals[15], 251);
    chk("mode3 residuals[3]", residuals[3], 7);

    // Four-beat SAD window after discarding the sweep's partial sums.
    idle(1);
    for (int k = 0; k < 4; k++) beat(200, 50, 0, 7, k, 0, k == 3, 0);
    chk("sad_valid pulse", sad_valid, 1);
    chk("sad[0] 4 beats", sad[0], 600);
    chk("sad[31] 4 beats", sad[31], 600);
    chk("sad_row", sad_row, 7);
    idle(0);
    chk("sad_valid one cycle", sad_valid, 0);
    chk("sad held", sad[10], 600);
    beat(3, 1, 0, 2, 0, 0, 1, 0);
    chk("next window from 0", sad[5], 2);

    // Backpressure: A captured, B held off, then both delivered in order.
    idle(0);
    res_ready = 1'b0;
    rec = 1'b1;
    beat(50, 20, 0, 3, 8'h11, 0, 0, 0);
    poi_data = 60; w_row_data = {LANES{8'd20}}; poi_addr = 8'h22; w_row = 4; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall in_ready", in_ready, 0);
      chk("stall poi_addr_wr", poi_addr_wr, 8'h11);
      chk("stall residuals[0]", residuals[0], 30);
      @(posedge clk);
      #2;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("B residuals[0]", residuals[0], 40);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rec = 1'b0;
    chk("delivered count", deliv.size(), 2);
    if (deliv.size() == 2) begin
      chk("delivered first", deliv[0], 8'h11);
      chk("delivered second", deliv[1], 8'h22);
    end

    // Saturation: 256 beats of |A-B| = 255 into a 12-bit accumulator.
    for (int k = 0; k < 256; k++) beat(255, 0, 0, 9, k, 0, k == 255, k == 0);
    chk("sat sad[0]", sad[0], 4095);
    chk("sat sad[31]", sad[31], 4095);

    // acc_clr together with an in_last beat, then acc_clr alone.
    for (int k = 0; k < 3; k++) beat(4, 3, 0, 1, k, 0, 0, 0);
    beat(9, 0, 0, 6, 0, 0, 1, 1);
    chk("clr+last sad_valid", sad_valid, 1);
    chk("clr+last sad[0]", sad[0], 9);
    chk("clr+last sad_row", sad_row, 6);
    for (int k = 0; k < 2; k++) beat(10, 5, 0, 1, k, 0, 0, 0);
    idle(1);
    chk("clr alone sad kept", sad[3], 9);
    beat(2, 0, 0, 1, 0, 0, 1, 0);
    chk("after clr alone", sad[3], 2);

    // Asynchronous reset mid-window.
    for (int k = 0; k < 3; k++) beat(100, 0, 0, 2, k, 0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("async res_valid", res_valid, 0);
    chk("async residuals[5]", residuals[5], 0);
    chk("async sad[5]", sad[5], 0);
    chk("async w_row_wr", w_row_wr, 0);
    chk("async poi_addr_wr", poi_addr_wr, 0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #2;
    beat(5, 2, 0, 11, 0, 0, 0, 0);
    beat(5, 2, 0, 11, 1, 0, 1, 0);
    chk("post-reset sad[0]", sad[0], 6);
    chk("post-reset sad_row", sad_row, 11);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
